// File: rtl/freq_gen_pkg.sv
// freq_gen shared types and helpers.
// State encoding, default counter width, phase-length clamp.
package freq_gen_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [31:0] clamp1(
    input logic [31:0] x
  );
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/freq_gen_phase_timer.sv
// Loadable down-counter timing one fout phase.
// expire is high in the last cycle of the loaded phase length.
module freq_gen_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - CNT_W'(1);
    end else if (enable && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = enable && (cnt == '0);

endmodule

// File: rtl/freq_gen.sv
// Programmable square-wave / burst generator.
// Drives the edge counter fin path; all outputs registered.
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [CNT_W-1:0] cfg_burst,
  input  logic             start,
  input  logic             stop,
  output logic             fout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] high_r;
  logic [CNT_W-1:0] low_r;
  logic [CNT_W-1:0] burst_r;
  logic             stop_pend;
  logic             pend_d;
  logic [CNT_W-1:0] cnt_d;
  logic             cfg_fire;
  logic [CNT_W-1:0] high_c;
  logic [CNT_W-1:0] low_c;
  logic [CNT_W-1:0] high_eff;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_exp;

  assign cfg_fire = cfg_valid & cfg_ready;
  assign high_c   = CNT_W'(clamp1(32'(cfg_high)));
  assign low_c    = CNT_W'(clamp1(32'(cfg_low)));
  // A config taken with start must time this run's first pulse.
  assign high_eff = cfg_fire ? high_c : high_r;
  assign tmr_en   = (state_q == HIGH) || (state_q == LOW);

  freq_gen_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .async_rst(async_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .enable   (tmr_en),
    .expire   (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = stop_pend;
    cnt_d    = pulse_cnt;
    tmr_load = 1'b0;
    tmr_val  = high_r;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = high_eff;
          cnt_d    = CNT_W'(1);
          pend_d   = 1'b0;
        end
      end
      HIGH: begin
        if (stop) pend_d = 1'b1;
        if (tmr_exp) begin
          state_d  = LOW;
          tmr_load = 1'b1;
          tmr_val  = low_r;
        end
      end
      LOW: begin
        if (stop) pend_d = 1'b1;
        if (tmr_exp) begin
          if (pend_d) begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end else if (burst_r != '0 &&
                       pulse_cnt == burst_r) begin
            state_d = DONE;
          end else begin
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = high_r;
            cnt_d    = pulse_cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q   <= IDLE;
      stop_pend <= 1'b0;
      pulse_cnt <= '0;
      fout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      stop_pend <= pend_d;
      pulse_cnt <= cnt_d;
      fout      <= (state_d == HIGH);
      busy      <= (state_d == HIGH) ||
                   (state_d == LOW);
      done      <= (state_d == DONE);
      cfg_ready <= (state_d == IDLE) ||
                   (state_d == DONE);
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      high_r  <= CNT_W'(1);
      low_r   <= CNT_W'(1);
      burst_r <= '0;
    end else if (cfg_fire) begin
      high_r  <= high_c;
      low_r   <= low_c;
      burst_r <= cfg_burst;
    end
  end

endmodule
